// File: rtl/vjtag_dr_bridge.sv
// User-side data registers of a virtual JTAG instance, bridging DR scans onto a
// single-port pixel memory with an auto-incrementing address and read prefetch.
module vjtag_dr_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [1:0]        ir_in,
    output logic [1:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_ADDR   = 2'b01;
    localparam logic [1:0] IR_WDATA  = 2'b10;
    localparam logic [1:0] IR_RDATA  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_bypass;
    logic [ADDR_W-1:0]   r_sr_addr;
    logic [DATA_W-1:0]   r_sr_wdata;
    logic [DATA_W-1:0]   r_sr_rdata;
    logic [ADDR_W-1:0]   r_addr_reg;
    logic [DATA_W-1:0]   r_read_buf;
    logic                r_rd_valid;
    logic                r_wrap_flag;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_mem_re;

    logic                w_udr_eff;
    logic                w_trigger;
    logic                w_issue;
    logic                w_capture;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_unused;

    assign w_unused   = ^{virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr, virtual_state_cir};
    assign w_udr_eff  = virtual_state_udr & ~virtual_state_cdr & ~virtual_state_sdr;
    assign w_trigger  = (ir_in != IR_BYPASS) & (w_udr_eff | virtual_state_uir);
    assign w_addr_inc = r_addr_reg + 1'b1;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign ir_out    = {r_wrap_flag, r_rd_valid};

    always_comb begin
        tdo = 1'b0;
        case (ir_in)
            IR_BYPASS: tdo = r_bypass;
            IR_ADDR:   tdo = r_sr_addr[0];
            IR_WDATA:  tdo = r_sr_wdata[0];
            default:   tdo = r_sr_rdata[0];
        endcase
    end

    // A new trigger always wins, so a pending read is dropped before it can
    // collide with the write strobe of the same update.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        if (w_trigger) begin
            w_state_next = S_ISSUE;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    w_issue      = 1'b1;
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (!r_mem_re) begin
                        w_capture    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            r_bypass    <= 1'b0;
            r_sr_addr   <= '0;
            r_sr_wdata  <= '0;
            r_sr_rdata  <= '0;
            r_addr_reg  <= '0;
            r_read_buf  <= '0;
            r_rd_valid  <= 1'b0;
            r_wrap_flag <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            if (virtual_state_cdr) begin
                case (ir_in)
                    IR_BYPASS: r_bypass   <= 1'b0;
                    IR_ADDR:   r_sr_addr  <= r_addr_reg;
                    IR_WDATA:  r_sr_wdata <= '0;
                    default:   r_sr_rdata <= r_read_buf;
                endcase
            end else if (virtual_state_sdr) begin
                case (ir_in)
                    IR_BYPASS: r_bypass   <= tdi;
                    IR_ADDR:   r_sr_addr  <= {tdi, r_sr_addr[ADDR_W-1:1]};
                    IR_WDATA:  r_sr_wdata <= {tdi, r_sr_wdata[DATA_W-1:1]};
                    default:   r_sr_rdata <= {tdi, r_sr_rdata[DATA_W-1:1]};
                endcase
            end else if (virtual_state_udr) begin
                case (ir_in)
                    IR_ADDR: begin
                        r_addr_reg  <= r_sr_addr;
                        r_wrap_flag <= 1'b0;
                    end
                    IR_WDATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr_reg;
                        r_mem_wdata <= r_sr_wdata;
                        r_addr_reg  <= w_addr_inc;
                        if (&r_addr_reg) begin
                            r_wrap_flag <= 1'b1;
                        end
                    end
                    IR_RDATA: begin
                        r_addr_reg <= w_addr_inc;
                        if (&r_addr_reg) begin
                            r_wrap_flag <= 1'b1;
                        end
                    end
                    default: r_addr_reg <= r_addr_reg;
                endcase
            end

            if (w_trigger) begin
                r_rd_valid <= 1'b0;
            end
            if (w_issue) begin
                r_mem_re   <= 1'b1;
                r_mem_addr <= r_addr_reg;
            end
            // Memory returns data the cycle after the strobe drops.
            if (w_capture) begin
                r_read_buf <= mem_rdata;
                r_rd_valid <= 1'b1;
            end
        end
    end

endmodule
